traffic_light_monitor: RTL and testbench

TRAFFIC_LIGHT_MONITOR -- requirements
Module: traffic_light_monitor

---
 rtl/traffic_light_monitor.sv | 179 +++++++++++++++++
 tb/tb_traffic_light_monitor.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Watches the two lamp heads of a two-road intersection and checks that
//   they step through the four-phase sequence with the configured dwell
//   times (A green -> A yellow -> B green -> B yellow -> A green ...).
//
//   Parameters : A_GREEN_CYC, A_YELLOW_CYC, B_GREEN_CYC, B_YELLOW_CYC
//                required dwell (cycles, 1..14) of phases 0..3.
//   Ports      : clk          rising-edge clock
//                reset        async active-low reset
//                LightA/B     observed lamps, one-hot {red,yellow,green}
//                phase        tracked phase while locked, else 0
//                locked       synchronised to the sequence
//                err_illegal  one-cycle pulse: lamp pattern not legal
//                err_seq      one-cycle pulse: phase skipped / went backwards
//                err_dur      one-cycle pulse: phase dwell too short / long
//                cycle_done   one-cycle pulse per correctly timed full cycle
//                cycle_count  wrapping count of cycle_done pulses
//                err_count    saturating count of error cycles
//   Option     : TLM_ERR_COUNT_EN -- when defined, err_count is a real
//                counter; otherwise it is tied to zero.
//
//   Every output is registered: the sample taken at edge N shows up on the
//   outputs right after edge N.
module traffic_light_monitor #(
  parameter logic [3:0] A_GREEN_CYC  = 4'd8,
  parameter logic [3:0] A_YELLOW_CYC = 4'd3,
  parameter logic [3:0] B_GREEN_CYC  = 4'd10,
  parameter logic [3:0] B_YELLOW_CYC = 4'd3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] LightA,
  input  logic [2:0] LightB,
  output logic [1:0] phase,
  output logic       locked,
  output logic       err_illegal,
  output logic       err_seq,
  output logic       err_dur,
  output logic       cycle_done,
  output logic [7:0] cycle_count,
  output logic [7:0] err_count
);

  typedef enum logic {SYNC, LOCKED} state_t;

  state_t     state;
  logic       first;    // no sample seen since reset
  logic [1:0] prev_ph;  // phase of the previous sample
  logic       prev_ok;  // previous sample was legal
  logic [1:0] cur_ph;   // phase being tracked while LOCKED
  logic [3:0] dwell;    // samples seen in cur_ph, 1 on entry

  // Decode the current sample
  logic       legal;
  logic [1:0] smp;
  logic [1:0] nxt_ph;
  logic [3:0] req;

  always_comb begin
    legal = 1'b1;
    smp   = 2'd0;
    case ({LightA, LightB})
      6'b001_100: smp = 2'd0;
      6'b010_100: smp = 2'd1;
      6'b100_001: smp = 2'd2;
      6'b100_010: smp = 2'd3;
      default:    legal = 1'b0;
    endcase
  end

  always_comb begin
    nxt_ph = cur_ph + 2'd1;
    case (cur_ph)
      2'd0:    req = A_GREEN_CYC;
      2'd1:    req = A_YELLOW_CYC;
      2'd2:    req = B_GREEN_CYC;
      default: req = B_YELLOW_CYC;
    endcase
  end

  // In SYNC we lock on the very first sample if it is phase 0, or on any
  // later sample whose phase differs from the one before it (an illegal
  // previous sample counts as different).
  logic lock_now;
  assign lock_now = first ? (smp == 2'd0) : (!prev_ok || smp != prev_ph);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= SYNC;
      first       <= 1'b1;
      prev_ph     <= 2'd0;
      prev_ok     <= 1'b0;
      cur_ph      <= 2'd0;
      dwell       <= 4'd0;
      phase       <= 2'd0;
      locked      <= 1'b0;
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_dur     <= 1'b0;
      cycle_done  <= 1'b0;
      cycle_count <= 8'd0;
    end else begin
      err_illegal <= 1'b0;
      err_seq     <= 1'b0;
      err_dur     <= 1'b0;
      cycle_done  <= 1'b0;
      first       <= 1'b0;
      if (!legal) begin
        // Illegal pattern overrides every other check this cycle.
        err_illegal <= 1'b1;
        state       <= SYNC;
        prev_ok     <= 1'b0;
        dwell       <= 4'd0;
        locked      <= 1'b0;
        phase       <= 2'd0;
      end else begin
        prev_ph <= smp;
        prev_ok <= 1'b1;
        case (state)
          SYNC: begin
            if (lock_now) begin
              state  <= LOCKED;
              cur_ph <= smp;
              dwell  <= 4'd1;
              locked <= 1'b1;
              phase  <= smp;
            end else begin
              locked <= 1'b0;
              phase  <= 2'd0;
            end
          end
          LOCKED: begin
            if (smp == cur_ph) begin
              // dwell == req means this sample is the (req+1)-th: overstay.
              if (dwell == req) begin
                err_dur <= 1'b1;
                state   <= SYNC;
                locked  <= 1'b0;
                phase   <= 2'd0;
              end else begin
                dwell <= dwell + 4'd1;
              end
            end else begin
              cur_ph <= smp;
              dwell  <= 4'd1;
              locked <= 1'b1;
              phase  <= smp;
              if (smp == nxt_ph) begin
                if (dwell != req) begin
                  err_dur <= 1'b1;
                end else if (cur_ph == 2'd3) begin
                  cycle_done  <= 1'b1;
                  cycle_count <= cycle_count + 8'd1;
                end
              end else begin
                // Out-of-order phase: no duration check, relock on it.
                err_seq <= 1'b1;
              end
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

`ifdef TLM_ERR_COUNT_EN
  // Counts from the registered pulses, so it trails them by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)
      err_count <= 8'd0;
    else if ((err_illegal || err_seq || err_dur) && err_count != 8'hFF)
      err_count <= err_count + 8'd1;
  end
`else
  assign err_count = 8'd0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor with hand-computed expectations.
module tb_traffic_light_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] LightA = 3'b000;
  logic [2:0] LightB = 3'b000;
  logic [1:0] phase;
  logic       locked;
  logic       err_illegal, err_seq, err_dur, cycle_done;
  logic [7:0] cycle_count, err_count;
  logic [2:0] errs;

  traffic_light_monitor dut (
    .clk(clk), .reset(reset), .LightA(LightA), .LightB(LightB),
    .phase(phase), .locked(locked), .err_illegal(err_illegal),
    .err_seq(err_seq), .err_dur(err_dur), .cycle_done(cycle_done),
    .cycle_count(cycle_count), .err_count(err_count)
  );

  always #5 clk = ~clk;
  assign errs = {err_illegal, err_seq, err_dur};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic [5:0] lamps(input int p);
    case (p)
      0:       return 6'b001_100;
      1:       return 6'b010_100;
      2:       return 6'b100_001;
      default: return 6'b100_010;
    endcase
  endfunction

  task automatic drive(input logic [5:0] ab);
    {LightA, LightB} = ab;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_n(input int p, input int n);
    for (int i = 0; i < n; i++) drive(lamps(p));
  endtask

  // Drive n samples of phase p expecting clean locked tracking.
  task automatic run_phase(input int p, input int n, input bit done_first);
    for (int i = 0; i < n; i++) begin
      drive(lamps(p));
      chk("run_locked", {31'd0, locked}, 32'd1);
      chk("run_phase", {30'd0, phase}, p);
      chk("run_errs", {29'd0, errs}, 32'd0);
      chk("run_done", {31'd0, cycle_done}, (i == 0 && done_first) ? 32'd1 : 32'd0);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset state
    reset = 1'b0;
    #3;
    chk("rst_phase", {30'd0, phase}, 32'd0);
    chk("rst_locked", {31'd0, locked}, 32'd0);
    chk("rst_errs", {29'd0, errs}, 32'd0);
    chk("rst_cnt", {24'd0, cycle_count}, 32'd0);
    chk("rst_errcnt", {24'd0, err_count}, 32'd0);
    do_reset();

    // Nominal sequence twice, plus the closing phase-0 sample
    run_phase(0, 8, 1'b0);
    run_phase(1, 3, 1'b0);
    run_phase(2, 10, 1'b0);
    run_phase(3, 3, 1'b0);
    run_phase(0, 8, 1'b1);
    run_phase(1, 3, 1'b0);
    run_phase(2, 10, 1'b0);
    run_phase(3, 3, 1'b0);
    run_phase(0, 1, 1'b1);
    chk("nom_cnt", {24'd0, cycle_count}, 32'd2);

    // 254 more clean cycles: cycle_count wraps 255 -> 0
    for (int c = 0; c < 254; c++) begin
      drive_n(0, 7); drive_n(1, 3); drive_n(2, 10); drive_n(3, 3); drive_n(0, 1);
    end
    chk("wrap_cnt", {24'd0, cycle_count}, 32'd0);
    chk("wrap_done", {31'd0, cycle_done}, 32'd1);
    chk("wrap_errs", {29'd0, errs}, 32'd0);

    // Phase 0 overstay
    do_reset();
    drive_n(0, 8);
    chk("ovr_pre_errs", {29'd0, errs}, 32'd0);
    chk("ovr_pre_lock", {31'd0, locked}, 32'd1);
    drive(lamps(0));
    chk("ovr_dur", {31'd0, err_dur}, 32'd1);
    chk("ovr_seq", {31'd0, err_seq}, 32'd0);
    chk("ovr_lock", {31'd0, locked}, 32'd0);
    chk("ovr_phase", {30'd0, phase}, 32'd0);
    drive(lamps(1));
    chk("ovr_relock", {31'd0, locked}, 32'd1);
    chk("ovr_rephase", {30'd0, phase}, 32'd1);
    chk("ovr_noerr", {29'd0, errs}, 32'd0);

    // Skip from phase 0 to phase 2
    do_reset();
    drive_n(0, 8);
    drive(lamps(2));
    chk("skip_seq", {31'd0, err_seq}, 32'd1);
    chk("skip_dur", {31'd0, err_dur}, 32'd0);
    chk("skip_lock", {31'd0, locked}, 32'd1);
    chk("skip_phase", {30'd0, phase}, 32'd2);
    drive(lamps(2));
    chk("skip_single", {29'd0, errs}, 32'd0);

    // Illegal pattern: both roads green
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(6'b001_001);
      chk("ill_pulse", {31'd0, err_illegal}, 32'd1);
      chk("ill_other", {30'd0, err_seq, err_dur}, 32'd0);
      chk("ill_lock", {31'd0, locked}, 32'd0);
      chk("ill_phase", {30'd0, phase}, 32'd0);
    end

    // Short yellow: phase 1 held 2 samples
    do_reset();
    drive_n(0, 8);
    drive_n(1, 2);
    chk("short_pre", {29'd0, errs}, 32'd0);
    drive(lamps(2));
    chk("short_dur", {31'd0, err_dur}, 32'd1);
    chk("short_seq", {31'd0, err_seq}, 32'd0);
    chk("short_lock", {31'd0, locked}, 32'd1);
    chk("short_phase", {30'd0, phase}, 32'd2);

    // Async reset mid phase 2 after one completed cycle
    do_reset();
    drive_n(0, 8); drive_n(1, 3); drive_n(2, 10); drive_n(3, 3);
    drive_n(0, 8); drive_n(1, 3); drive_n(2, 4);
    chk("mid_pre_cnt", {24'd0, cycle_count}, 32'd1);
    chk("mid_pre_phase", {30'd0, phase}, 32'd2);
    #1;
    reset = 1'b0;
    #1;
    chk("mid_phase", {30'd0, phase}, 32'd0);
    chk("mid_locked", {31'd0, locked}, 32'd0);
    chk("mid_cnt", {24'd0, cycle_count}, 32'd0);
    chk("mid_errs", {29'd0, errs}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    // First sample after release is phase 2: stays unlocked
    drive(lamps(2));
    chk("rel_first", {31'd0, locked}, 32'd0);
    drive(lamps(2));
    chk("rel_same", {31'd0, locked}, 32'd0);
    drive(lamps(3));
    chk("rel_lock", {31'd0, locked}, 32'd1);
    chk("rel_phase", {30'd0, phase}, 32'd3);
    chk("rel_errs", {29'd0, errs}, 32'd0);

`ifdef TLM_ERR_COUNT_EN
    do_reset();
    for (int i = 0; i < 300; i++) drive(6'b000_000);
    drive(lamps(0));
    chk("errcnt_sat", {24'd0, err_count}, 32'd255);
`else
    drive(6'b000_000);
    drive(6'b000_000);
    chk("errcnt_off", {24'd0, err_count}, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
